i2c_read_scheduler: RTL and testbench

I2C_READ_SCHEDULER -- requirements
Module: i2c_read_scheduler

---
 rtl/i2c_read_scheduler_if.sv | 34 +++
 rtl/i2c_read_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_read_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_read_scheduler_if
// Brief    : Requester and byte-level I2C command bus of i2c_read_scheduler.
// Revision : 1.0
// ============================================================================
interface i2c_read_scheduler_if;
    logic [1:0]  req;
    logic [13:0] req_dev;
    logic [15:0] req_reg;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        done;
    logic [7:0]  done_data;
    logic        done_nack;
    logic        busy;

    modport master (
        input  req, req_dev, req_reg, cmd_ready, done, done_data, done_nack,
        output gnt, rsp_valid, rsp_data, rsp_err, cmd_valid, cmd_op, cmd_data, busy
    );

    modport slave (
        output req, req_dev, req_reg, cmd_ready, done, done_data, done_nack,
        input  gnt, rsp_valid, rsp_data, rsp_err, cmd_valid, cmd_op, cmd_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : i2c_read_scheduler
// Brief    : Round-robin arbiter running a 7-command I2C register read per grant.
// Revision : 1.0
// ============================================================================
module i2c_read_scheduler #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  wire                   CLK100MHZ,
    input  wire                   reset,
    i2c_read_scheduler_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_START     = 3'd0;
    localparam logic [2:0] c_OP_WRITE     = 3'd1;
    localparam logic [2:0] c_OP_READ_NACK = 3'd3;
    localparam logic [2:0] c_OP_STOP      = 3'd4;
    localparam logic [2:0] c_STEP_READ    = 3'd5;
    localparam logic [2:0] c_STEP_STOP    = 3'd6;
    localparam int         c_TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TLAST   = c_TW'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_state;
    logic [2:0]      r_step, w_step;
    logic [6:0]      r_dev, w_dev;
    logic [7:0]      r_reg, w_reg;
    logic            r_idx, w_idx;
    logic            r_last, w_last;
    logic            r_err, w_err;
    logic [7:0]      r_data, w_data;
    logic [c_TW-1:0] r_timer, w_timer;
    logic [1:0]      r_gnt, w_gnt;
    logic [1:0]      r_rsp_valid, w_rsp_valid;
    logic [7:0]      r_rsp_data, w_rsp_data;
    logic            r_rsp_err, w_rsp_err;
    logic            r_cmd_valid, w_cmd_valid;
    logic [2:0]      r_cmd_op, w_cmd_op;
    logic [7:0]      r_cmd_data, w_cmd_data;
    logic            r_busy, w_busy;
    logic            w_enter_issue;
    logic            w_enter_resp;

    // {op, data} of each step of the fixed register-read sequence
    function automatic logic [10:0] f_cmd(input logic [2:0] step, input logic [6:0] dev,
                                          input logic [7:0] rg);
        case (step)
            3'd0, 3'd3: f_cmd = {c_OP_START, 8'h00};
            3'd1:       f_cmd = {c_OP_WRITE, dev, 1'b0};
            3'd2:       f_cmd = {c_OP_WRITE, rg};
            3'd4:       f_cmd = {c_OP_WRITE, dev, 1'b1};
            3'd5:       f_cmd = {c_OP_READ_NACK, 8'h00};
            default:    f_cmd = {c_OP_STOP, 8'h00};
        endcase
    endfunction

    always_comb begin
        w_state       = r_state;
        w_step        = r_step;
        w_dev         = r_dev;
        w_reg         = r_reg;
        w_idx         = r_idx;
        w_last        = r_last;
        w_err         = r_err;
        w_data        = r_data;
        w_timer       = r_timer;
        w_gnt         = r_gnt;
        w_rsp_valid   = 2'b00;
        w_rsp_data    = r_rsp_data;
        w_rsp_err     = r_rsp_err;
        w_cmd_valid   = r_cmd_valid;
        w_cmd_op      = r_cmd_op;
        w_cmd_data    = r_cmd_data;
        w_enter_issue = 1'b0;
        w_enter_resp  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    // on a tie the requester not served last wins
                    w_idx         = (bus.req == 2'b11) ? ~r_last : bus.req[1];
                    w_dev         = w_idx ? bus.req_dev[13:7] : bus.req_dev[6:0];
                    w_reg         = w_idx ? bus.req_reg[15:8] : bus.req_reg[7:0];
                    w_gnt         = w_idx ? 2'b10 : 2'b01;
                    w_step        = 3'd0;
                    w_err         = 1'b0;
                    w_data        = 8'h00;
                    w_enter_issue = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    w_cmd_valid = 1'b0;
                    w_timer     = '0;
                    w_state     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.done) begin
                    if (r_step == c_STEP_STOP) begin
                        w_enter_resp = 1'b1;
                    end else begin
                        if (r_step == c_STEP_READ) begin
                            w_data = bus.done_data;
                        end
                        if (bus.done_nack && (r_step == 3'd1 || r_step == 3'd2 || r_step == 3'd4)) begin
                            w_err  = 1'b1;
                            w_step = c_STEP_STOP;
                        end else begin
                            w_step = r_step + 3'd1;
                        end
                        w_enter_issue = 1'b1;
                    end
                end else if (r_timer == c_TLAST) begin
                    w_err = 1'b1;
                    if (r_step == c_STEP_STOP) begin
                        w_enter_resp = 1'b1;
                    end else begin
                        w_step        = c_STEP_STOP;
                        w_enter_issue = 1'b1;
                    end
                end else begin
                    w_timer = r_timer + c_TW'(1);
                end
            end
            ST_RESP: begin
                w_gnt   = 2'b00;
                w_last  = r_idx;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_enter_issue) begin
            w_state                = ST_ISSUE;
            w_cmd_valid            = 1'b1;
            {w_cmd_op, w_cmd_data} = f_cmd(w_step, w_dev, w_reg);
        end

        // response is presented while in RESP so the requester can drop req before IDLE
        if (w_enter_resp) begin
            w_state     = ST_RESP;
            w_rsp_valid = r_gnt;
            w_rsp_data  = w_err ? 8'h00 : w_data;
            w_rsp_err   = w_err;
        end

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_step      <= 3'd0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_idx       <= 1'b0;
            r_last      <= 1'b1;
            r_err       <= 1'b0;
            r_data      <= 8'd0;
            r_timer     <= '0;
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= 8'd0;
            r_rsp_err   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 3'd0;
            r_cmd_data  <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_step      <= w_step;
            r_dev       <= w_dev;
            r_reg       <= w_reg;
            r_idx       <= w_idx;
            r_last      <= w_last;
            r_err       <= w_err;
            r_data      <= w_data;
            r_timer     <= w_timer;
            r_gnt       <= w_gnt;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_cmd_valid <= w_cmd_valid;
            r_cmd_op    <= w_cmd_op;
            r_cmd_data  <= w_cmd_data;
            r_busy      <= w_busy;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_op    = r_cmd_op;
    assign bus.cmd_data  = r_cmd_data;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_read_scheduler
// Brief    : Directed scoreboard bench with an I2C byte-master responder model.
// Revision : 1.0
// ============================================================================
module tb_i2c_read_scheduler;

    localparam int c_TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    i2c_read_scheduler_if bus ();

    i2c_read_scheduler #(.TIMEOUT_CYCLES(c_TMO)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_cmd_q [$];
    logic [10:0] exp_rsp_q [$];

    int rdy_delay = 0;
    int nack_at   = -1;
    int hang_from = -1;
    logic [7:0] rd_byte = 8'h00;
    int cmd_no    = 0;
    int acc_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmds(input logic [6:0] dev, input logic [7:0] rg, input int last, input bit stop);
        logic [10:0] seq [7];
        seq[0] = {3'd0, 8'h00};
        seq[1] = {3'd1, dev, 1'b0};
        seq[2] = {3'd1, rg};
        seq[3] = {3'd0, 8'h00};
        seq[4] = {3'd1, dev, 1'b1};
        seq[5] = {3'd3, 8'h00};
        seq[6] = {3'd4, 8'h00};
        for (int i = 0; i <= last; i++) exp_cmd_q.push_back(seq[i]);
        if (stop && last < 6) exp_cmd_q.push_back(seq[6]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (bus.req != 2'b00 && n < 400) begin
            @(posedge clk); #2;
            bus.req = bus.req & ~bus.rsp_valid;
            n++;
        end
        check("all_requests_served", {30'd0, bus.req}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       {30'd0, bus.gnt},       32'd0);
        check({tag, "_rsp_valid"}, {30'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_data"},  {24'd0, bus.rsp_data},  32'd0);
        check({tag, "_rsp_err"},   {31'd0, bus.rsp_err},   32'd0);
        check({tag, "_cmd_valid"}, {31'd0, bus.cmd_valid}, 32'd0);
        check({tag, "_cmd_op"},    {29'd0, bus.cmd_op},    32'd0);
        check({tag, "_cmd_data"},  {24'd0, bus.cmd_data},  32'd0);
        check({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
    endtask

    // Byte-level I2C master model: accepts commands, returns done two cycles later
    initial begin : responder
        int stall = 0;
        int done_wait = 0;
        int gap = 0;
        int cur_idx = 0;
        bit seen = 0;
        bit gap_on = 0;
        logic [10:0] cap = '0;
        logic [10:0] first = '0;
        logic [10:0] exp;
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;
        bus.done_data = 8'h00;
        bus.done_nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.done      = 1'b0;
            bus.done_nack = 1'b0;
            if (bus.busy !== 1'b1) cmd_no = 0;
            if (gap_on) begin
                gap++;
                if (bus.cmd_valid === 1'b1) begin
                    check("timeout_gap_cycles", gap, c_TMO);
                    gap_on = 0;
                end
            end
            if (bus.cmd_ready) begin
                bus.cmd_ready = 1'b0;
                acc_total++;
                exp = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 11'h7FF;
                check("cmd_accepted", {21'd0, cap}, {21'd0, exp});
                cur_idx = cmd_no;
                cmd_no++;
                if (hang_from >= 0 && cur_idx >= hang_from) begin
                    done_wait = 0;
                    gap       = 0;
                    gap_on    = (cap[10:8] != 3'd4);
                end else begin
                    done_wait = 2;
                end
            end else if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) begin
                    bus.done      = 1'b1;
                    bus.done_nack = (cur_idx == nack_at);
                    bus.done_data = (cap[10:8] == 3'd3) ? rd_byte : ~rd_byte;
                end
            end else if (bus.cmd_valid === 1'b1) begin
                if (!seen) begin
                    seen  = 1;
                    first = {bus.cmd_op, bus.cmd_data};
                    stall = 0;
                end else begin
                    check("cmd_stable_while_stalled", {20'd0, bus.cmd_valid, bus.cmd_op, bus.cmd_data},
                          {20'd0, 1'b1, first});
                end
                if (stall < rdy_delay) begin
                    stall++;
                end else begin
                    bus.cmd_ready = 1'b1;
                    cap  = {bus.cmd_op, bus.cmd_data};
                    seen = 0;
                end
            end
        end
    end

    // Response scoreboard
    initial begin : rsp_monitor
        logic [10:0] exp;
        forever begin
            @(posedge clk); #1;
            if (bus.rsp_valid != 2'b00) begin
                exp = (exp_rsp_q.size() > 0) ? exp_rsp_q.pop_front() : 11'h000;
                check("rsp", {21'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {21'd0, exp});
                check("gnt_matches_rsp", {30'd0, bus.gnt}, {30'd0, bus.rsp_valid});
            end
        end
    end

    initial begin : stimulus
        int base;
        int n;
        bus.req     = 2'b00;
        bus.req_dev = 14'd0;
        bus.req_reg = 16'd0;

        @(posedge clk); #2;
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // basic read from requester 0
        bus.req_dev = {7'h00, 7'h40};
        bus.req_reg = {8'h00, 8'h00};
        rd_byte     = 8'hA5;
        push_cmds(7'h40, 8'h00, 6, 1);
        exp_rsp_q.push_back({2'b01, 1'b0, 8'hA5});
        bus.req = 2'b01;
        @(posedge clk); #2;
        check("t1_gnt", {30'd0, bus.gnt}, 32'd1);
        check("t1_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check("t1_cmd_op_start", {29'd0, bus.cmd_op}, 32'd0);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        wait_rsp();
        idle(3);

        // tie after reset: requester 0 first, then 1
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        idle(2);
        bus.req_dev = {7'h33, 7'h11};
        bus.req_reg = {8'h44, 8'h22};
        rd_byte     = 8'h5A;
        push_cmds(7'h11, 8'h22, 6, 1);
        push_cmds(7'h33, 8'h44, 6, 1);
        exp_rsp_q.push_back({2'b01, 1'b0, 8'h5A});
        exp_rsp_q.push_back({2'b10, 1'b0, 8'h5A});
        bus.req = 2'b11;
        @(posedge clk); #2;
        check("t2_first_gnt", {30'd0, bus.gnt}, 32'd1);
        wait_rsp();
        idle(3);

        // address NACK on step 1 goes straight to STOP
        nack_at     = 1;
        rd_byte     = 8'hFF;
        bus.req_dev = {7'h00, 7'h50};
        bus.req_reg = {8'h00, 8'h10};
        push_cmds(7'h50, 8'h10, 1, 1);
        exp_rsp_q.push_back({2'b01, 1'b1, 8'h00});
        bus.req = 2'b01;
        wait_rsp();
        idle(3);

        // NACK on the read-address write (step 4), requester 1
        nack_at     = 4;
        bus.req_dev = {7'h21, 7'h00};
        bus.req_reg = {8'h9C, 8'h00};
        push_cmds(7'h21, 8'h9C, 4, 1);
        exp_rsp_q.push_back({2'b10, 1'b1, 8'h00});
        bus.req = 2'b10;
        wait_rsp();
        idle(3);
        nack_at = -1;

        // step 3 never completes, STOP also times out
        hang_from   = 3;
        bus.req_dev = {7'h00, 7'h12};
        bus.req_reg = {8'h00, 8'h34};
        push_cmds(7'h12, 8'h34, 3, 1);
        exp_rsp_q.push_back({2'b01, 1'b1, 8'h00});
        bus.req = 2'b01;
        wait_rsp();
        idle(3);
        hang_from = -1;

        // cmd_ready stalled 5 cycles on every command
        rdy_delay   = 5;
        rd_byte     = 8'h3C;
        bus.req_dev = {7'h2A, 7'h00};
        bus.req_reg = {8'h07, 8'h00};
        push_cmds(7'h2A, 8'h07, 6, 1);
        exp_rsp_q.push_back({2'b10, 1'b0, 8'h3C});
        bus.req = 2'b10;
        wait_rsp();
        idle(3);
        rdy_delay = 0;

        // reset during the step-4 WAIT abandons the transaction
        bus.req_dev = {7'h00, 7'h1C};
        bus.req_reg = {8'h00, 8'h55};
        push_cmds(7'h1C, 8'h55, 4, 0);
        base = acc_total;
        bus.req = 2'b01;
        n = 0;
        while (acc_total < base + 5 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("t6_accepted_before_reset", acc_total - base, 5);
        bus.req = 2'b00;
        reset   = 1'b1;
        @(posedge clk); #2;
        check_reset_outputs("midreset");
        reset = 1'b0;
        idle(6);

        bus.req_dev = {7'h00, 7'h60};
        bus.req_reg = {8'h00, 8'h0F};
        rd_byte     = 8'h99;
        push_cmds(7'h60, 8'h0F, 6, 1);
        exp_rsp_q.push_back({2'b01, 1'b0, 8'h99});
        bus.req = 2'b01;
        @(posedge clk); #2;
        check("t6_gnt_after_reset", {30'd0, bus.gnt}, 32'd1);
        wait_rsp();
        idle(4);

        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("rsp_queue_drained", exp_rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
